// File: rtl/fetch_ctrl.sv
// fetch_ctrl: pipeline control sequencer for the fetch stage.
// Arbitrates branch redirects, halt detection, multi-cycle and load-use
// stalls (priority in that order) and drives registered fetch controls.
// Ports:
//   clk, reset (async, active-low)
//   br_valid/br_taken/br_target  : resolved branch from execute
//   load_use                     : one-cycle stall request from decode
//   mc_start/mc_len              : multi-cycle op, stalls mc_len+1 cycles
//   if_valid/if_instr            : fetch output, scanned for HALT_OP
//   resume/resume_pc             : restart request while halted
//   stall/flush/pc_sel/branch_target : fetch stage controls
//   decode_squash                : invalidate decode/execute latches
//   halt, state, redirect_count  : status
module fetch_ctrl #(
    parameter int          ADDR_W        = 8,
    parameter logic [3:0]  HALT_OP       = 4'b1111,
    parameter int          SQUASH_CYCLES = 2,
    parameter int          CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              load_use,
    input  logic              mc_start,
    input  logic [1:0]        mc_len,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic              resume,
    input  logic [ADDR_W-1:0] resume_pc,
    output logic              stall,
    output logic              flush,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] branch_target,
    output logic              decode_squash,
    output logic              halt,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_SQUASH = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Shared down-counter for stall length and squash length.
    localparam int            CW      = 8;
    localparam logic [CW-1:0] SQ_INIT = CW'(SQUASH_CYCLES - 1);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                stall_q, flush_q, pc_sel_q, squash_q, halt_q;
    logic [ADDR_W-1:0]   target_q;
    logic [CNT_W-1:0]    rcnt_q;

    logic redirect_w, halt_w;
    assign redirect_w = br_valid & br_taken;
    assign halt_w     = if_valid & (if_instr[15:12] == HALT_OP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
            flush_q  <= 1'b0;
            pc_sel_q <= 1'b0;
            squash_q <= 1'b0;
            halt_q   <= 1'b0;
            target_q <= '0;
            rcnt_q   <= '0;
        end else begin
            // pc_sel/flush are single-cycle pulses
            pc_sel_q <= 1'b0;
            flush_q  <= 1'b0;
            case (state_q)
                S_HALTED: begin
                    // Only resume is honoured; halt/stall hold otherwise
                    if (resume) begin
                        state_q  <= S_SQUASH;
                        cnt_q    <= SQ_INIT;
                        stall_q  <= 1'b0;
                        halt_q   <= 1'b0;
                        pc_sel_q <= 1'b1;
                        flush_q  <= 1'b1;
                        squash_q <= 1'b1;
                        target_q <= resume_pc;
                    end
                end
                default: begin
                    if (redirect_w) begin
                        // stall must drop: fetch ignores pc_sel while stalled
                        state_q  <= S_SQUASH;
                        cnt_q    <= SQ_INIT;
                        stall_q  <= 1'b0;
                        pc_sel_q <= 1'b1;
                        flush_q  <= 1'b1;
                        squash_q <= 1'b1;
                        target_q <= br_target;
                        rcnt_q   <= rcnt_q + CNT_W'(1);
                    end else if (state_q == S_SQUASH) begin
                        // stall/halt requests here came from squashed instrs
                        if (cnt_q == '0) begin
                            state_q  <= S_RUN;
                            squash_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end else if (halt_w) begin
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                        stall_q <= 1'b1;
                    end else if (state_q == S_STALL) begin
                        // new stall requests do not extend a running stall
                        if (cnt_q == '0) begin
                            state_q <= S_RUN;
                            stall_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end else if (mc_start) begin
                        state_q <= S_STALL;
                        stall_q <= 1'b1;
                        cnt_q   <= CW'(mc_len);
                    end else if (load_use) begin
                        state_q <= S_STALL;
                        stall_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign stall          = stall_q;
    assign flush          = flush_q;
    assign pc_sel         = pc_sel_q;
    assign branch_target  = target_q;
    assign decode_squash  = squash_q;
    assign halt           = halt_q;
    assign state          = state_q;
    assign redirect_count = rcnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Pipeline control sequencer for the 8-bit-PC fetch stage. It arbitrates between branch redirects from execute, load-use and multi-cycle stalls from decode/execute, and halt detection. It drives the fetch stage's stall, flush, PC_sel and branch_target inputs, plus a downstream squash. All outputs are registered, and the block sits between the hazard sources and the fetch stage.

Parameters:
ADDR_W, 8, PC/target width
HALT_OP, 4'b1111, opcode (instr[15:12]) that halts fetch
SQUASH_CYCLES, 2, cycles decode_squash is held after a redirect (>=1)
CNT_W, 16, width of the redirect performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
br_valid  in  1  execute has resolved a branch this cycle
br_taken  in  1  resolved branch taken (qualified by br_valid)
br_target  in  ADDR_W  taken-branch target
load_use  in  1  decode load-use hazard, one-cycle stall request
mc_start  in  1  execute starts a multi-cycle op
mc_len  in  2  extra stall cycles for the multi-cycle op (stall lasts mc_len+1 cycles)
if_valid  in  1  fetch output valid
if_instr  in  16  fetch output instruction
resume  in  1  restart request while halted
resume_pc  in  ADDR_W  restart PC
stall  out  1  to fetch stall
flush  out  1  to fetch flush
pc_sel  out  1  to fetch PC_sel
branch_target  out  ADDR_W  to fetch branch_target
decode_squash  out  1  invalidate decode/execute latches
halt  out  1  core halted
state  out  2  0 RUN, 1 STALL, 2 SQUASH, 3 HALTED
redirect_count  out  CNT_W  taken redirects since reset, wraps

Behaviour:
- Reset (reset=0, async) drives all outputs to 0 and state to RUN, and clears the internal counters.
- Latency: an event sampled on edge N is visible on outputs after edge N, for exactly one registered cycle.
- Event priority, evaluated every cycle: redirect > halt > multi-cycle stall > load_use.
  - redirect = br_valid & br_taken.
  - halt = if_valid & if_instr[15:12]==HALT_OP.
- Redirect, from any state except HALTED:
  - Next cycle: pc_sel=1, flush=1, stall=0, branch_target=br_target, decode_squash=1.
  - redirect_count increments (wraps at 2^CNT_W).
  - The state goes to SQUASH with a squash counter set to SQUASH_CYCLES-1.
  - pc_sel and flush are single-cycle pulses. stall must be 0 in the redirect cycle because fetch ignores PC_sel while stalled.
  - A redirect arriving during STALL aborts the stall: the stall counter is cleared.
- SQUASH: pc_sel=0, flush=0, decode_squash=1 while the counter is nonzero; the counter decrements each cycle. Exit to RUN when it reaches 0.
  - When SQUASH_CYCLES=1, SQUASH lasts 0 extra cycles.
  - A new redirect in SQUASH restarts the sequence.
  - Stall and halt requests in SQUASH are dropped, because the requesting instruction was squashed.
- Stalls from RUN:
  - mc_start: stall=1 for mc_len+1 cycles. The state is STALL, a down-counter runs, and the block returns to RUN when it expires.
  - load_use: stall=1 for one cycle, state STALL.
  - mc_start during STALL is ignored. load_use during STALL does not extend the stall; it is re-requested by decode.
- Halt from RUN or STALL (if no redirect):
  - Next cycle: halt=1, stall=1, state HALTED. Both are held.
  - In HALTED, br_valid, load_use and mc_start are ignored.
  - resume=1 in HALTED: next cycle pc_sel=1, flush=1, stall=0, halt=0, branch_target=resume_pc, then state SQUASH as for a redirect. redirect_count does not increment.
- branch_target holds its last loaded value when pc_sel=0.
- Simultaneous redirect and halt: the redirect wins. The halting instruction is on the wrong path.
- Reset mid-stall or mid-squash: everything returns to RUN immediately, asynchronously.

Test Plan:
- Reset then idle: reset low 3 cycles, release. Required: all outputs 0, state=0, and they stay 0 with no requests.
- Redirect: br_valid=1, br_taken=1, br_target=8'h2A for 1 cycle. Required next cycle: pc_sel=1, flush=1, stall=0, target=8'h2A, decode_squash=1. Then 1 more squash cycle (SQUASH_CYCLES=2), then RUN. redirect_count=1.
- Multi-cycle stall: mc_start=1, mc_len=2. Required: stall=1 for exactly 3 cycles, state=1, then 0. A redirect (target 8'h10) on the 2nd stall cycle makes stall drop next cycle with pc_sel=1 and target=8'h10.
- Halt/resume: if_valid=1, if_instr=16'hF000. Required: halt=1 and stall=1 held 10 cycles, with br_valid/br_taken ignored (count unchanged). Then resume=1, resume_pc=8'h05. Required next cycle: pc_sel=1, target=8'h05, halt=0, stall=0.
- Priority: in one cycle, redirect to 8'h40, if_instr=16'hF123 valid, and load_use=1. Required: only the redirect pulse, no halt, no stall.
- Counter wrap: CNT_W=4, 17 redirects. Required: redirect_count=1. Async reset asserted mid-squash: outputs 0 with no clock edge.
